// File: rtl/riscv_checkpoint_monitor.sv
// Checkpoint monitor for RISCV_TOP: compares each retired-instruction count against a
// preloaded (count, expected output) table and reports PASS or FAIL with diagnostics.
module riscv_checkpoint_monitor #(
   parameter int unsigned NUM_TEST = 17,
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   input  logic             TBL_WE,
   input  logic [IDX_W-1:0] TBL_IDX,
   input  logic [31:0]      TBL_NUM_INST,
   input  logic [31:0]      TBL_ANS,
   input  logic [31:0]      NUM_INST,
   input  logic [31:0]      OUTPUT_PORT,
   input  logic             HALT,
   output logic             DONE,
   output logic             PASS,
   output logic [2:0]       FAIL_CODE,
   output logic [IDX_W-1:0] FAIL_IDX,
   output logic [31:0]      FAIL_VAL,
   output logic [IDX_W-1:0] PASS_CNT,
   output logic [31:0]      CYCLE
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_e;
   typedef enum logic [2:0] {
      FC_NONE       = 3'd0,
      FC_MISMATCH   = 3'd1,
      FC_MISSED     = 3'd2,
      FC_EARLY_HALT = 3'd3,
      FC_TIMEOUT    = 3'd4
   } fail_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    pass_cnt_q, pass_cnt_d;
   logic [DATA_W-1:0]   cycle_q, cycle_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   fail_e               fail_code_q, fail_code_d;
   logic [IDX_W-1:0]    fail_idx_q, fail_idx_d;
   logic [DATA_W-1:0]   fail_val_q, fail_val_d;

   logic [DATA_W-1:0]   tbl_inst_q [NUM_TEST];
   logic [DATA_W-1:0]   tbl_ans_q  [NUM_TEST];

   logic                tbl_wr;
   logic                ptr_live;
   logic [DATA_W-1:0]   ent_inst;
   logic [DATA_W-1:0]   ent_ans;
   logic [DATA_W-1:0]   cycle_inc;
   logic                cmp_fail;

   assign tbl_wr   = (state_q == ST_IDLE) && TBL_WE && (TBL_IDX < IDX_W'(NUM_TEST));
   assign ptr_live = (ptr_q < IDX_W'(NUM_TEST));

   // Checkpoint table, writable only while idle
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < int'(NUM_TEST); i++) begin
            tbl_inst_q[i] <= '0;
            tbl_ans_q[i]  <= '0;
         end
      end else if (tbl_wr) begin
         tbl_inst_q[TBL_IDX] <= TBL_NUM_INST;
         tbl_ans_q[TBL_IDX]  <= TBL_ANS;
      end
   end

   always_comb begin
      ent_inst = '0;
      ent_ans  = '0;
      if (ptr_live) begin
         ent_inst = tbl_inst_q[ptr_q];
         ent_ans  = tbl_ans_q[ptr_q];
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         pass_cnt_q  <= '0;
         cycle_q     <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_code_q <= FC_NONE;
         fail_idx_q  <= '0;
         fail_val_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         pass_cnt_q  <= pass_cnt_d;
         cycle_q     <= cycle_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_code_q <= fail_code_d;
         fail_idx_q  <= fail_idx_d;
         fail_val_q  <= fail_val_d;
      end
   end

   // Next state: checkpoint compare first, then HALT, then timeout
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      pass_cnt_d  = pass_cnt_q;
      cycle_d     = cycle_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_code_d = fail_code_q;
      fail_idx_d  = fail_idx_q;
      fail_val_d  = fail_val_q;
      cmp_fail    = 1'b0;
      cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + DATA_W'(1);

      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (START) begin
               state_d     = ST_RUN;
               ptr_d       = '0;
               pass_cnt_d  = '0;
               cycle_d     = '0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_code_d = FC_NONE;
               fail_idx_d  = '0;
               fail_val_d  = '0;
            end
         end
         ST_RUN: begin
            cycle_d = cycle_inc;
            if (ptr_live) begin
               if (NUM_INST == ent_inst) begin
                  if (OUTPUT_PORT == ent_ans) begin
                     ptr_d      = ptr_q + IDX_W'(1);
                     pass_cnt_d = pass_cnt_q + IDX_W'(1);
                  end else begin
                     cmp_fail    = 1'b1;
                     fail_code_d = FC_MISMATCH;
                     fail_val_d  = OUTPUT_PORT;
                  end
               end else if (NUM_INST > ent_inst) begin
                  cmp_fail    = 1'b1;
                  fail_code_d = FC_MISSED;
                  fail_val_d  = NUM_INST;
               end
            end

            if (cmp_fail) begin
               state_d    = ST_FAIL;
               done_d     = 1'b1;
               fail_idx_d = ptr_q;
            end else if (HALT) begin
               done_d = 1'b1;
               if (ptr_d == IDX_W'(NUM_TEST)) begin
                  state_d = ST_PASS;
                  pass_d  = 1'b1;
               end else begin
                  state_d     = ST_FAIL;
                  fail_code_d = FC_EARLY_HALT;
                  fail_idx_d  = ptr_d;
                  fail_val_d  = NUM_INST;
               end
            end else if ((TIMEOUT != 0) && (cycle_inc >= DATA_W'(TIMEOUT))) begin
               state_d     = ST_FAIL;
               done_d      = 1'b1;
               fail_code_d = FC_TIMEOUT;
               fail_idx_d  = ptr_d;
               fail_val_d  = NUM_INST;
            end
         end
      endcase
   end

   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign FAIL_CODE = fail_code_q;
   assign FAIL_IDX  = fail_idx_q;
   assign FAIL_VAL  = fail_val_q;
   assign PASS_CNT  = pass_cnt_q;
   assign CYCLE     = cycle_q;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Bench for riscv_checkpoint_monitor: directed scenario table, corner sequences and
// randomized tables/streams checked against a trace-level reference model.
module tb_riscv_checkpoint_monitor;

   localparam int NT  = 17;
   localparam int IW  = 5;
   localparam int TO  = 50;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          START, TBL_WE, HALT;
   logic [IW-1:0] TBL_IDX;
   logic [31:0]   TBL_NUM_INST, TBL_ANS, NUM_INST, OUTPUT_PORT;
   logic          DONE, PASS;
   logic [2:0]    FAIL_CODE;
   logic [IW-1:0] FAIL_IDX, PASS_CNT;
   logic [31:0]   FAIL_VAL, CYCLE;

   riscv_checkpoint_monitor #(.NUM_TEST(NT), .IDX_W(IW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RSTn(RSTn), .START(START), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
      .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .NUM_INST(NUM_INST),
      .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .DONE(DONE), .PASS(PASS),
      .FAIL_CODE(FAIL_CODE), .FAIL_IDX(FAIL_IDX), .FAIL_VAL(FAIL_VAL),
      .PASS_CNT(PASS_CNT), .CYCLE(CYCLE));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] ni;
      logic [31:0] op;
      logic        halt;
   } step_t;

   typedef struct {
      logic [2:0]  code;
      logic [4:0]  idx;
      logic [31:0] val;
      logic [4:0]  cnt;
      logic [31:0] cyc;
      logic        pass;
      logic        done;
   } res_t;

   typedef struct {
      logic [31:0] bad_ni, bad_op, skip_a, skip_b, halt_ni;
      res_t        exp;
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic [31:0] fx_inst [NT];
   logic [31:0] fx_ans  [NT];
   logic [31:0] t_inst  [NT];
   logic [31:0] t_ans   [NT];
   step_t       tr [$];
   vec_t        vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_res(input string tag, input res_t g, input res_t e);
      chk({tag, ".done"}, 32'(g.done), 32'(e.done));
      chk({tag, ".pass"}, 32'(g.pass), 32'(e.pass));
      chk({tag, ".code"}, 32'(g.code), 32'(e.code));
      chk({tag, ".idx"},  32'(g.idx),  32'(e.idx));
      chk({tag, ".val"},  g.val,       e.val);
      chk({tag, ".cnt"},  32'(g.cnt),  32'(e.cnt));
      chk({tag, ".cyc"},  g.cyc,       e.cyc);
   endtask

   function automatic res_t mk(input int code, input int idx, input logic [31:0] val,
                               input int cnt, input int cyc, input bit pass);
      res_t r;
      r.code = 3'(code); r.idx = 5'(idx); r.val = val; r.cnt = 5'(cnt);
      r.cyc = 32'(cyc); r.pass = pass; r.done = 1'b1;
      return r;
   endfunction

   // Trace-level model: walk the stream and report the first exit event
   function automatic res_t model();
      res_t r;
      int   p = 0;
      int   cyc = 0;
      r = mk(0, 0, 32'h0, 0, 0, 1'b0);
      r.done = 1'b0;
      foreach (tr[k]) begin
         cyc++;
         if (p < NT && tr[k].ni == t_inst[p]) begin
            if (tr[k].op == t_ans[p]) p++;
            else begin r = mk(1, p, tr[k].op, p, cyc, 0); return r; end
         end else if (p < NT && tr[k].ni > t_inst[p]) begin
            r = mk(2, p, tr[k].ni, p, cyc, 0); return r;
         end
         if (tr[k].halt) begin
            if (p == NT) r = mk(0, 0, 32'h0, p, cyc, 1);
            else         r = mk(3, p, tr[k].ni, p, cyc, 0);
            return r;
         end
         if (cyc >= TO) begin r = mk(4, p, tr[k].ni, p, cyc, 0); return r; end
      end
      return r;
   endfunction

   function automatic logic [31:0] golden(input logic [31:0] ni);
      for (int i = 0; i < NT; i++) if (fx_inst[i] == ni) return fx_ans[i];
      return 32'h0;
   endfunction

   task automatic build_vec(input vec_t v);
      step_t       s;
      logic [31:0] ni = 32'h0;
      tr.delete();
      for (int k = 0; k < 80; k++) begin
         s.ni   = ni;
         s.op   = (ni == v.bad_ni) ? v.bad_op : golden(ni);
         s.halt = (ni == v.halt_ni);
         tr.push_back(s);
         if (s.halt) break;
         ni = (ni == v.skip_a) ? v.skip_b : ni + 32'd2;
      end
   endtask

   task automatic do_reset();
      RSTn = 1'b0; START = 1'b0; TBL_WE = 1'b0; HALT = 1'b0; TBL_IDX = '0;
      TBL_NUM_INST = '0; TBL_ANS = '0; NUM_INST = '0; OUTPUT_PORT = '0;
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
   endtask

   task automatic load_table();
      for (int i = 0; i < NT; i++) begin
         TBL_WE = 1'b1; TBL_IDX = IW'(i);
         TBL_NUM_INST = t_inst[i]; TBL_ANS = t_ans[i];
         @(negedge CLK);
      end
      TBL_WE = 1'b0;
   endtask

   task automatic run_trace(input string tag, input bit wr_in_run, output res_t r);
      bit seen = 1'b0;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      chk({tag, ".start_done"},  32'(DONE), 32'h0);
      chk({tag, ".start_code"},  32'(FAIL_CODE), 32'h0);
      chk({tag, ".start_cycle"}, CYCLE, 32'h0);
      for (int k = 0; k < tr.size() + 4; k++) begin
         if (DONE) begin seen = 1'b1; break; end
         if (k < tr.size()) begin
            NUM_INST = tr[k].ni; OUTPUT_PORT = tr[k].op; HALT = tr[k].halt;
         end
         TBL_WE = wr_in_run && (k == 1);
         TBL_IDX = 5'd4; TBL_NUM_INST = 32'hc; TBL_ANS = 32'h999;
         @(negedge CLK);
      end
      TBL_WE = 1'b0; HALT = 1'b0;
      if (!seen) chk({tag, ".done_wait"}, 32'(DONE), 32'h1);
      r.done = DONE; r.pass = PASS; r.code = FAIL_CODE; r.idx = FAIL_IDX;
      r.val = FAIL_VAL; r.cnt = PASS_CNT; r.cyc = CYCLE;
   endtask

   initial begin
      res_t  got;
      step_t s;
      fx_inst = '{32'h4, 32'h6, 32'h8, 32'ha, 32'hc, 32'h10, 32'h14, 32'h18, 32'h1c,
                  32'h20, 32'h24, 32'h28, 32'h30, 32'h34, 32'h3c, 32'h40, 32'h46};
      fx_ans  = '{32'heec, 32'h0, 32'h11, 32'h22, 32'hef0, 32'h5a, 32'h0, 32'h7,
                  32'h100, 32'h33, 32'h44, 32'hffff_ffff, 32'h1, 32'h2, 32'h3,
                  32'h1234, 32'h0};
      // {bad_ni, bad_op, skip_a, skip_b, halt_ni, expected}
      vecs[0] = '{32'hffff, 32'h0, 32'hffff, 32'h0, 32'h46, mk(0, 0, 32'h0, 17, 36, 1)};
      vecs[1] = '{32'hc, 32'h5, 32'hffff, 32'h0, 32'h46, mk(1, 4, 32'h5, 4, 7, 0)};
      vecs[2] = '{32'hffff, 32'h0, 32'h8, 32'hb, 32'h46, mk(2, 3, 32'hb, 3, 6, 0)};
      vecs[3] = '{32'hffff, 32'h0, 32'hffff, 32'h0, 32'h34, mk(3, 14, 32'h34, 14, 27, 0)};
      vecs[4] = '{32'hffff, 32'h0, 32'hffff, 32'h0, 32'h44, mk(3, 16, 32'h44, 16, 35, 0)};
      vecs[5] = '{32'h46, 32'h1, 32'hffff, 32'h0, 32'h46, mk(1, 16, 32'h1, 16, 36, 0)};

      do_reset();
      chk("rst.done", 32'(DONE), 32'h0);
      chk("rst.pass", 32'(PASS), 32'h0);
      chk("rst.code", 32'(FAIL_CODE), 32'h0);
      chk("rst.cycle", CYCLE, 32'h0);
      chk("rst.cnt", 32'(PASS_CNT), 32'h0);
      t_inst = fx_inst; t_ans = fx_ans;
      load_table();

      for (int v = 0; v < 6; v++) begin
         build_vec(vecs[v]);
         run_trace($sformatf("vec%0d", v), 1'b0, got);
         cmp_res($sformatf("vec%0d", v), got, vecs[v].exp);
      end

      // NUM_INST stuck at zero runs into the timeout
      tr.delete();
      for (int k = 0; k < 60; k++) begin s.ni = 0; s.op = 0; s.halt = 0; tr.push_back(s); end
      run_trace("timeout", 1'b0, got);
      cmp_res("timeout", got, mk(4, 0, 32'h0, 0, TO, 0));

      // Restart keeps the table; a write attempted during RUN is dropped
      build_vec(vecs[0]);
      run_trace("restart", 1'b1, got);
      cmp_res("restart", got, vecs[0].exp);

      // Asynchronous reset in the middle of a run
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      for (int k = 0; k < 10; k++) begin
         NUM_INST = tr[k].ni; OUTPUT_PORT = tr[k].op; HALT = 1'b0;
         @(negedge CLK);
      end
      chk("midrun.cnt", 32'(PASS_CNT), 32'h6);
      chk("midrun.cycle", CYCLE, 32'ha);
      #2 RSTn = 1'b0;
      #1;
      chk("async.cnt", 32'(PASS_CNT), 32'h0);
      chk("async.cycle", CYCLE, 32'h0);
      chk("async.done", 32'(DONE), 32'h0);
      @(negedge CLK); RSTn = 1'b1;
      for (int i = 0; i < NT; i++) begin t_inst[i] = 0; t_ans[i] = 0; end
      run_trace("lost_tbl", 1'b0, got);
      cmp_res("lost_tbl", got, mk(2, 1, 32'h2, 1, 2, 0));

      // Random tables and streams against the model
      for (int t = 0; t < 25; t++) begin
         logic [31:0] acc, ni;
         int gp;
         do_reset();
         acc = 32'($urandom_range(1, 3));
         for (int i = 0; i < NT; i++) begin
            t_inst[i] = acc; t_ans[i] = 32'($urandom_range(0, 3));
            acc = acc + 32'($urandom_range(0, 3));
         end
         load_table();
         tr.delete(); ni = 0; gp = 0;
         for (int k = 0; k < 60; k++) begin
            bit hit = (gp < NT) && (t_inst[gp] == ni);
            s.ni = ni;
            s.op = hit ? t_ans[gp] : $urandom;
            if (hit && $urandom_range(0, 24) == 0) s.op = s.op ^ 32'h1;
            s.halt = (k == 59) || ((gp >= NT) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 49) == 0));
            tr.push_back(s);
            if (hit) gp++;
            if (gp < NT && t_inst[gp] == ni) ni = ni;
            else if ($urandom_range(0, 19) == 0) ni = ni + 32'd2;
            else ni = ni + 32'd1;
         end
         run_trace($sformatf("rnd%0d", t), 1'b0, got);
         cmp_res($sformatf("rnd%0d", t), got, model());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
